// File: rtl/fsk_tx_ctrl_if.sv
// fsk_tx_ctrl_if: bit-source handshake and NCO drive signals of the FSK burst controller.
interface fsk_tx_ctrl_if #(
   parameter int LEN_W = 12
);
   logic               start;
   logic [LEN_W-1:0]   len;
   logic               bit_in;
   logic               bit_valid;
   logic               bit_ready;
   logic [24:0]        phi_inc;
   logic signed [24:0] freq_mod;
   logic               nco_en;
   logic               busy;
   logic               sym_strobe;
   logic               underrun;
   logic               done;
   modport master (
      output start, len, bit_in, bit_valid,
      input  bit_ready, phi_inc, freq_mod, nco_en, busy, sym_strobe, underrun, done
   );
   modport slave (
      input  start, len, bit_in, bit_valid,
      output bit_ready, phi_inc, freq_mod, nco_en, busy, sym_strobe, underrun, done
   );
endinterface

// File: rtl/fsk_tx_ctrl.sv
// fsk_tx_ctrl: burst scheduler driving the CPFSK NCO increment, FM word and clock enable.
module fsk_tx_ctrl #(
   parameter int          SYM_CYCLES = 32,
   parameter int          PRE_BITS   = 16,
   parameter logic [15:0] SYNC_WORD  = 16'hD391,
   parameter int          TAIL_BITS  = 2,
   parameter int          LEN_W      = 12,
   parameter logic [24:0] CARRIER    = 25'd6291456,
   parameter logic [24:0] DF         = 25'd1835008
) (
   input  logic         clk,
   input  logic         reset_n,
   fsk_tx_ctrl_if.slave bus
);
   localparam int CW   = $clog2(SYM_CYCLES);
   localparam int MAXB = (PRE_BITS > 16) ? ((PRE_BITS > TAIL_BITS) ? PRE_BITS : TAIL_BITS)
                                         : ((TAIL_BITS > 16) ? TAIL_BITS : 16);
   localparam int IW   = $clog2(MAXB);
   localparam logic [CW-1:0] SYM_LAST  = CW'(SYM_CYCLES - 1);
   localparam logic [IW-1:0] PRE_LAST  = IW'(PRE_BITS - 1);
   localparam logic [IW-1:0] SYNC_LAST = IW'(15);
   localparam logic [IW-1:0] TAIL_LAST = IW'(TAIL_BITS - 1);

   typedef enum logic [2:0] {IDLE, PRE, SYNC, PAY, TAIL} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [LEN_W-1:0]  rem_q, rem_d, len_q, len_d;
   logic [15:0]       sync_q, sync_d;
   logic [24:0]       freq_q, freq_d, phi_q;
   logic              strobe_q, strobe_d, done_q, done_d, busy_q, busy_d;
   logic              en_q, en_d, under_q, under_d;
   logic              last_sym, ready, fetched;

   function automatic logic [24:0] fm(input logic b);
      return b ? DF : -DF;
   endfunction

   // bit_ready looks only at state and counters so the source never sees a loop through bit_valid
   assign last_sym = cnt_q == SYM_LAST;
   assign ready    = last_sym && ((state_q == SYNC && idx_q == SYNC_LAST && len_q != '0) ||
                                  (state_q == PAY && rem_q > LEN_W'(1)));
   assign fetched  = bus.bit_valid & bus.bit_in;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      rem_d    = rem_q;
      len_d    = len_q;
      sync_d   = sync_q;
      freq_d   = freq_q;
      busy_d   = busy_q;
      en_d     = en_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      under_d  = ready & ~bus.bit_valid;
      if (state_q == IDLE) begin
         if (bus.start && !done_q) begin
            state_d  = PRE;
            cnt_d    = '0;
            idx_d    = '0;
            len_d    = bus.len;
            freq_d   = DF;
            strobe_d = 1'b1;
            busy_d   = 1'b1;
            en_d     = 1'b1;
         end
      end else if (!last_sym) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d    = '0;
         strobe_d = 1'b1;
         idx_d    = idx_q + IW'(1);
         case (state_q)
            PRE: begin
               // next preamble bit ~(k+1)[0] equals k[0]
               freq_d = fm(idx_q[0]);
               if (idx_q == PRE_LAST) begin
                  state_d = SYNC;
                  idx_d   = '0;
                  sync_d  = {SYNC_WORD[14:0], 1'b0};
                  freq_d  = fm(SYNC_WORD[15]);
               end
            end
            SYNC: begin
               sync_d = sync_q << 1;
               freq_d = fm(sync_q[15]);
               if (idx_q == SYNC_LAST) begin
                  idx_d   = '0;
                  rem_d   = len_q;
                  state_d = (len_q != '0) ? PAY : TAIL;
                  freq_d  = (len_q != '0) ? fm(fetched) : '0;
               end
            end
            PAY: begin
               idx_d   = idx_q;
               rem_d   = (rem_q > LEN_W'(1)) ? rem_q - LEN_W'(1) : '0;
               state_d = (rem_q > LEN_W'(1)) ? PAY : TAIL;
               freq_d  = (rem_q > LEN_W'(1)) ? fm(fetched) : '0;
            end
            TAIL: begin
               freq_d = '0;
               if (idx_q == TAIL_LAST) begin
                  state_d  = IDLE;
                  idx_d    = '0;
                  strobe_d = 1'b0;
                  done_d   = 1'b1;
                  busy_d   = 1'b0;
                  en_d     = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         rem_q    <= '0;
         len_q    <= '0;
         sync_q   <= '0;
         freq_q   <= '0;
         phi_q    <= CARRIER;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         en_q     <= 1'b0;
         under_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         len_q    <= len_d;
         sync_q   <= sync_d;
         freq_q   <= freq_d;
         phi_q    <= CARRIER;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         en_q     <= en_d;
         under_q  <= under_d;
      end
   end

   assign bus.bit_ready  = ready;
   assign bus.phi_inc    = phi_q;
   assign bus.freq_mod   = $signed(freq_q);
   assign bus.nco_en     = en_q;
   assign bus.busy       = busy_q;
   assign bus.sym_strobe = strobe_q;
   assign bus.underrun   = under_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_fsk_tx_ctrl.sv
// tb_fsk_tx_ctrl: directed bench for the FSK burst scheduler.
module tb_fsk_tx_ctrl;
   localparam logic signed [24:0] PDF = 25'sd1835008;
   localparam logic signed [24:0] NDF = -25'sd1835008;
   localparam logic [24:0]        CAR = 25'd6291456;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] sw  = 16'hD391;
   logic [15:0] pat = 16'b1011_0010_0110_1001;
   int checks = 0;
   int errors = 0;
   int o_busy, o_strobe, o_hs, o_under, o_under_at, o_fetch_at, o_done, o_phi_bad, o_glitch, o_pos_bad;
   bit o_fin;
   logic signed [24:0] o_sym [0:63];

   fsk_tx_ctrl_if #(.LEN_W(12)) bus ();
   fsk_tx_ctrl_if #(.LEN_W(12)) bus2 ();
   fsk_tx_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   fsk_tx_ctrl #(.SYM_CYCLES(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

   always #5 clk = ~clk;

   // Starts a burst and records what the DUT does until done (or a cycle budget runs out).
   task automatic run_burst(input int n, input int drop, input bit poke);
      int cyc, pos, fetch;
      logic signed [24:0] last;
      o_busy = 0; o_strobe = 0; o_hs = 0; o_under = 0; o_under_at = -1; o_fetch_at = -100;
      o_done = 0; o_phi_bad = 0; o_glitch = 0; o_pos_bad = 0; o_fin = 0;
      for (int k = 0; k < 64; k++) o_sym[k] = 'x;
      cyc = 0; pos = 0; fetch = 0; last = '0;
      @(negedge clk);
      bus.len = 12'(n); bus.bit_in = pat[15]; bus.bit_valid = (drop != 1); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (!o_fin && cyc < 3000) begin
         cyc++;
         bus.bit_in = pat[15 - (fetch % 16)];
         bus.bit_valid = (fetch + 1 != drop);
         if (poke && cyc == 100) begin bus.start = 1'b1; bus.len = 12'd5; end
         if (poke && cyc == 101) bus.start = 1'b0;
         if (bus.sym_strobe) begin
            if (o_strobe < 64) o_sym[o_strobe] = bus.freq_mod;
            o_strobe++; pos = 0;
         end else begin
            pos++;
            if (bus.freq_mod !== last) o_glitch++;
         end
         last = bus.freq_mod;
         if (bus.busy) o_busy++;
         if (bus.phi_inc !== CAR) o_phi_bad++;
         if (bus.underrun) begin o_under++; o_under_at = cyc; end
         if (bus.bit_ready) begin
            o_hs++;
            if (pos != 31) o_pos_bad++;
            fetch++;
            if (fetch == drop) o_fetch_at = cyc;
         end
         if (bus.done) begin
            o_done++; o_fin = 1;
            if (poke) bus.start = 1'b1;
         end else @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({bus.busy, bus.nco_en, bus.bit_ready, bus.sym_strobe, bus.underrun, bus.done} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {bus.busy, bus.nco_en, bus.bit_ready, bus.sym_strobe, bus.underrun, bus.done}); end
      checks++; if (bus.freq_mod !== 25'sd0) begin errors++; $display("FAIL reset_freq got %0d want 0", bus.freq_mod); end
      checks++; if (bus.phi_inc !== CAR) begin errors++; $display("FAIL reset_phi got %0d want %0d", bus.phi_inc, CAR); end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({bus.busy, bus.done, bus2.busy} !== 3'b0) begin errors++; $display("FAIL reset_idle got %b want 000", {bus.busy, bus.done, bus2.busy}); end
   endtask

   task automatic test_basic();
      int bad, first;
      logic signed [24:0] exp_v, got_v, want_v;
      run_burst(8, 0, 0);
      checks++; if (o_fin !== 1'b1) begin errors++; $display("FAIL basic_timeout got %0d want 1", o_fin); end
      checks++; if (o_busy !== 1344) begin errors++; $display("FAIL basic_busy got %0d want 1344", o_busy); end
      checks++; if (o_strobe !== 42) begin errors++; $display("FAIL basic_strobes got %0d want 42", o_strobe); end
      checks++; if (o_hs !== 8) begin errors++; $display("FAIL basic_handshakes got %0d want 8", o_hs); end
      checks++; if (o_pos_bad !== 0) begin errors++; $display("FAIL basic_ready_pos got %0d off-slot want 0", o_pos_bad); end
      checks++; if (o_done !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", o_done); end
      checks++; if (o_phi_bad !== 0) begin errors++; $display("FAIL basic_phi got %0d bad cycles want 0", o_phi_bad); end
      checks++; if (o_glitch !== 0) begin errors++; $display("FAIL basic_fm_offstrobe got %0d want 0", o_glitch); end
      checks++; if (o_under !== 0) begin errors++; $display("FAIL basic_underrun got %0d want 0", o_under); end
      bad = 0; first = -1; got_v = '0; want_v = '0;
      for (int k = 0; k < 42; k++) begin
         exp_v = (k < 16) ? ((k % 2 == 0) ? PDF : NDF) :
                 (k < 32) ? (sw[31 - k] ? PDF : NDF) :
                 (k < 40) ? (pat[47 - k] ? PDF : NDF) : 25'sd0;
         if (o_sym[k] !== exp_v) begin
            if (bad == 0) begin first = k; got_v = o_sym[k]; want_v = exp_v; end
            bad++;
         end
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_freq_seq %0d wrong, symbol %0d got %0d want %0d", bad, first, got_v, want_v); end
   endtask

   task automatic test_len0();
      run_burst(0, 0, 0);
      checks++; if (o_busy !== 1088) begin errors++; $display("FAIL len0_busy got %0d want 1088", o_busy); end
      checks++; if (o_hs !== 0) begin errors++; $display("FAIL len0_handshakes got %0d want 0", o_hs); end
      checks++; if (o_strobe !== 34) begin errors++; $display("FAIL len0_strobes got %0d want 34", o_strobe); end
      checks++; if (o_sym[31] !== PDF) begin errors++; $display("FAIL len0_last_sync got %0d want %0d", o_sym[31], PDF); end
      checks++; if ({o_sym[32], o_sym[33]} !== 50'd0) begin errors++; $display("FAIL len0_tail got %0d,%0d want 0,0", o_sym[32], o_sym[33]); end
      checks++; if (o_done !== 1) begin errors++; $display("FAIL len0_done got %0d want 1", o_done); end
   endtask

   task automatic test_underrun();
      run_burst(4, 3, 0);
      checks++; if (o_under !== 1) begin errors++; $display("FAIL under_count got %0d want 1", o_under); end
      checks++; if (o_under_at !== o_fetch_at + 1) begin errors++; $display("FAIL under_timing got cycle %0d want %0d", o_under_at, o_fetch_at + 1); end
      checks++; if (o_sym[34] !== NDF) begin errors++; $display("FAIL under_sym35 got %0d want %0d", o_sym[34], NDF); end
      checks++; if (o_sym[35] !== PDF) begin errors++; $display("FAIL under_sym36 got %0d want %0d", o_sym[35], PDF); end
      checks++; if (o_busy !== 1216) begin errors++; $display("FAIL under_busy got %0d want 1216", o_busy); end
      checks++; if (o_hs !== 4) begin errors++; $display("FAIL under_handshakes got %0d want 4", o_hs); end
   endtask

   task automatic test_back_to_back();
      int n;
      run_burst(8, 0, 1);
      checks++; if (o_busy !== 1344) begin errors++; $display("FAIL b2b_midstart_busy got %0d want 1344", o_busy); end
      checks++; if (o_strobe !== 42) begin errors++; $display("FAIL b2b_strobes got %0d want 42", o_strobe); end
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle_start got busy %b want 0", bus.busy); end
      bus.len = 12'd8;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if ({bus.busy, bus.sym_strobe, bus.nco_en} !== 3'b111) begin errors++; $display("FAIL b2b_restart_flags got %b want 111", {bus.busy, bus.sym_strobe, bus.nco_en}); end
      checks++; if (bus.freq_mod !== PDF) begin errors++; $display("FAIL b2b_restart_freq got %0d want %0d", bus.freq_mod, PDF); end
      n = 1;
      while (bus.busy && n < 2000) begin @(negedge clk); if (bus.busy) n++; end
      checks++; if (n !== 1344) begin errors++; $display("FAIL b2b_second_busy got %0d want 1344", n); end
   endtask

   task automatic test_reset_mid();
      int dn;
      @(negedge clk);
      bus.len = 12'd8; bus.bit_valid = 1'b1; bus.bit_in = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (33 * 32 + 5) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", bus.busy); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({bus.busy, bus.nco_en, bus.bit_ready, bus.sym_strobe, bus.underrun, bus.done} !== 6'b0) begin errors++; $display("FAIL rmid_async_flags got %b want 000000", {bus.busy, bus.nco_en, bus.bit_ready, bus.sym_strobe, bus.underrun, bus.done}); end
      checks++; if ({bus.freq_mod, bus.phi_inc} !== {25'd0, CAR}) begin errors++; $display("FAIL rmid_async_words got %0d,%0d want 0,%0d", bus.freq_mod, bus.phi_inc, CAR); end
      dn = 0;
      repeat (4) begin @(negedge clk); if (bus.done) dn++; end
      reset_n = 1'b1;
      repeat (40) begin @(negedge clk); if (bus.done || bus.busy) dn++; end
      checks++; if (dn !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dn); end
      run_burst(8, 0, 0);
      checks++; if ({o_busy, o_hs, o_done} !== {32'd1344, 32'd8, 32'd1}) begin errors++; $display("FAIL rmid_after got busy %0d hs %0d done %0d want 1344 8 1", o_busy, o_hs, o_done); end
   endtask

   task automatic test_max_len();
      int b, hs, st, dn, u, cyc;
      @(negedge clk);
      bus2.len = 12'd4095; bus2.bit_in = 1'b1; bus2.bit_valid = 1'b1; bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      b = 0; hs = 0; st = 0; dn = 0; u = 0; cyc = 0;
      while (dn == 0 && cyc < 20000) begin
         cyc++;
         if (bus2.busy) b++;
         if (bus2.bit_ready) hs++;
         if (bus2.sym_strobe) st++;
         if (bus2.underrun) u++;
         if (bus2.done) dn++; else @(negedge clk);
      end
      checks++; if (b !== 8258) begin errors++; $display("FAIL max_busy got %0d want 8258", b); end
      checks++; if (hs !== 4095) begin errors++; $display("FAIL max_handshakes got %0d want 4095", hs); end
      checks++; if (st !== 4129) begin errors++; $display("FAIL max_strobes got %0d want 4129", st); end
      checks++; if ({dn, u} !== {32'd1, 32'd0}) begin errors++; $display("FAIL max_done_under got %0d,%0d want 1,0", dn, u); end
   endtask

   initial begin
      bus.start = 1'b0; bus.len = '0; bus.bit_in = 1'b0; bus.bit_valid = 1'b0;
      bus2.start = 1'b0; bus2.len = '0; bus2.bit_in = 1'b0; bus2.bit_valid = 1'b0;
      test_reset();
      test_basic();
      test_len0();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      test_max_len();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fsk_tx_ctrl.md
Name: fsk_tx_ctrl

Overview:
Frame scheduler and configuration controller for the CPFSK modulator NCO (32 MHz clk, Rb = 1 MHz, fc = 6 MHz, ±1.75 MHz deviation).
- On a start request it builds one burst: alternating preamble, sync word, LEN payload bits pulled from an upstream source, then a carrier-only tail.
- It drives the NCO carrier increment, frequency-modulation word and clock enable, one symbol every SYM_CYCLES clocks.
- It sits between the framing/data source and the NCO instance inside the FSK transmitter.

Parameters:
- SYM_CYCLES, 32: clocks per symbol (32 MHz / 1 MHz).
- PRE_BITS, 16: preamble length in symbols; pattern 1,0,1,0,...
- SYNC_WORD, 16'hD391: sync word, sent MSB first.
- TAIL_BITS, 2: carrier-only symbols after the payload.
- LEN_W, 12: width of the payload length field.
- CARRIER, 25'd6291456: NCO phase increment for 6 MHz.
- DF, 25'd1835008: NCO frequency offset for 1.75 MHz.

Ports:
- clk  in  1  sample clock, 32 MHz.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle burst request; honoured only in IDLE.
- len  in  LEN_W  payload bit count, sampled with start; 0 is legal.
- bit_in  in  1  payload bit from the source.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  controller takes bit_in this cycle.
- phi_inc  out  25  NCO carrier increment.
- freq_mod  out  25  signed NCO frequency offset.
- nco_en  out  1  NCO clken.
- busy  out  1  burst in progress.
- sym_strobe  out  1  pulses on the first cycle of each symbol.
- underrun  out  1  one-cycle pulse when a payload bit was missing.
- done  out  1  one-cycle pulse at end of burst.

Behaviour:
- Reset, asynchronous:
  - State = IDLE; all counters = 0.
  - freq_mod = 0, nco_en = 0, busy = 0, bit_ready = 0, sym_strobe = 0, underrun = 0, done = 0.
  - phi_inc = CARRIER; it is constant at all times.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is issued.
- All outputs are registered except bit_ready, which is combinational from state and counters only (never from bit_valid).
- States: IDLE -> PREAMBLE -> SYNC -> PAYLOAD -> TAIL -> IDLE.
  - PAYLOAD is skipped when len = 0: SYNC goes directly to TAIL.
- Symbol counter sym_cnt runs 0..SYM_CYCLES-1 in every non-IDLE state. It wraps to 0 and advances the bit index on the cycle after count SYM_CYCLES-1.
- Start timing:
  - start in IDLE at cycle t: at t+1 the state is PREAMBLE, sym_cnt = 0, sym_strobe = 1, busy = 1, nco_en = 1, freq_mod = +DF (first preamble bit is 1).
  - start while busy is ignored and len is not resampled.
- Bit-to-frequency mapping: bit 1 -> +DF, bit 0 -> -DF (25-bit two's complement). TAIL -> 0.
- freq_mod changes only on symbol boundaries, i.e. cycles where sym_strobe = 1.
- Preamble and sync:
  - PREAMBLE bit k = ~k[0], for k = 0..PRE_BITS-1.
  - SYNC sends SYNC_WORD[15] down to SYNC_WORD[0].
- Payload fetch:
  - bit_ready = 1 when sym_cnt = SYM_CYCLES-1 and the next symbol is a payload bit.
  - That is the last sync symbol with len != 0, or a PAYLOAD symbol with remaining bits > 1.
  - If bit_valid = 1, the bit is accepted and used for the next symbol.
  - If bit_valid = 0, a 0 bit is substituted, underrun pulses on the next cycle, and the payload count still advances. Burst timing is never stretched.
- Exactly len handshakes occur per burst.
- Tail and completion:
  - TAIL holds freq_mod = 0 for TAIL_BITS symbols.
  - After the last tail cycle: state = IDLE, nco_en = 0, busy = 0, done = 1 for one cycle, freq_mod = 0.
  - A start in the same cycle as done is ignored.
  - A start in the cycle after done is accepted.
- Burst duration (busy high) = (PRE_BITS + 16 + len + TAIL_BITS) * SYM_CYCLES cycles.
- Payload counter width is LEN_W. The maximum len, 2^LEN_W - 1, is sent without wrap.

Test Plan:
- Reset, then start with len = 8 and bit_valid held high, bits 10110010:
  - busy high for exactly 42*32 = 1344 cycles.
  - 42 sym_strobe pulses.
  - 8 bit_ready handshakes, each at sym_cnt = 31.
  - freq_mod sequence: 16 alternating ±1835008, then sync D391, then the payload, then 2 symbols of 0.
  - done pulses once; phi_inc = 6291456 throughout.
- len = 0: no bit_ready; busy for 34*32 = 1088 cycles; TAIL directly after the 16th sync symbol.
- len = 4 with bit_valid low on the 3rd fetch:
  - underrun pulses once, one cycle after that fetch.
  - Symbol 35 is -DF.
  - Burst length is unchanged at 38*32 = 1216 cycles.
- Start re-asserted mid-burst and again in the done cycle: both ignored. A start one cycle after done begins a new burst with freq_mod = +DF on the next cycle.
- reset_n pulsed low during PAYLOAD:
  - outputs return to reset values asynchronously; no done pulse.
  - a subsequent start produces a full, correct burst.
- len = 4095: exactly 4095 handshakes and a (34+4095)*32 cycle burst, with no counter wrap.
